if_id_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Owns the fetch address, runs a multi-cycle request/ready handshake with instruction memory, and presents the registered instruction fields (PC+4, Rs, Rt, Rd, Shamt, Func, Imm, Opcode) that the ID stage and the ID/EXE register consume. Handles hazard-unit stalls, taken-branch/jump redirects, and bubble insertion when memory is slow.

---
 rtl/if_id_stage.sv | 142 ++++++++++++++
 tb/tb_if_id_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: MIPS instruction-fetch stage and IF/ID pipeline register.
// Ports: clk/rst_n; Stall, PCSrc and BranchTarget from the hazard and branch logic; Imem_* fetch handshake;
//        IF_ID_* registered instruction, PC+4 and decoded field slices for the ID stage.
// Latency: 1 cycle from Imem_Ready to IF/ID. Imem_Req is a pure function of state (FETCH/DRAIN).
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    output logic        IF_ID_Valid,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCplus4,
    output logic [5:0]  IF_ID_Opcode,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt,
    output logic [4:0]  IF_ID_Rd,
    output logic [4:0]  IF_ID_Shamt,
    output logic [5:0]  IF_ID_Func,
    output logic [15:0] IF_ID_Imm
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_addr, fetch_addr_nxt;
    logic [31:0] redirect_pc, redirect_pc_nxt;
    logic [31:0] hold_buf, hold_buf_nxt;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] ifid_word;

    // Wraps modulo 2^32, so fetching 0xFFFF_FFFC continues at 0.
    assign pc_plus4 = fetch_addr + 32'd4;

    // Request depends only on state so Stall/PCSrc never reach the memory port combinationally.
    assign Imem_Req  = (state == FETCH) || (state == DRAIN);
    assign Imem_Addr = fetch_addr;

    always_comb begin
        state_nxt       = state;
        fetch_addr_nxt  = fetch_addr;
        redirect_pc_nxt = redirect_pc;
        hold_buf_nxt    = hold_buf;
        ifid_load       = 1'b0;
        ifid_bubble     = 1'b0;
        ifid_word       = Imem_Data;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (PCSrc) begin
                    ifid_bubble = 1'b1;
                    if (Imem_Ready) begin
                        fetch_addr_nxt = BranchTarget;
                    end else begin
                        // Address must stay put until the outstanding request completes.
                        redirect_pc_nxt = BranchTarget;
                        state_nxt       = DRAIN;
                    end
                end else if (Imem_Ready) begin
                    if (Stall) begin
                        // Memory cannot be asked to repeat, so park the word until ID accepts it.
                        hold_buf_nxt = Imem_Data;
                        state_nxt    = HOLD;
                    end else begin
                        ifid_load      = 1'b1;
                        fetch_addr_nxt = pc_plus4;
                    end
                end else if (!Stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    ifid_bubble    = 1'b1;
                    fetch_addr_nxt = BranchTarget;
                    state_nxt      = FETCH;
                end else if (!Stall) begin
                    ifid_load      = 1'b1;
                    ifid_word      = hold_buf;
                    fetch_addr_nxt = pc_plus4;
                    state_nxt      = FETCH;
                end
            end
            DRAIN: begin
                ifid_bubble = PCSrc || !Stall;
                if (PCSrc) begin
                    redirect_pc_nxt = BranchTarget;
                end
                if (Imem_Ready) begin
                    // The returned word belongs to the squashed path; the newest target wins.
                    fetch_addr_nxt = PCSrc ? BranchTarget : redirect_pc;
                    state_nxt      = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            fetch_addr    <= RESET_PC;
            redirect_pc   <= 32'h0;
            hold_buf      <= 32'h0;
            IF_ID_Valid   <= 1'b0;
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCplus4 <= 32'h0;
        end else begin
            state       <= state_nxt;
            fetch_addr  <= fetch_addr_nxt;
            redirect_pc <= redirect_pc_nxt;
            hold_buf    <= hold_buf_nxt;
            if (ifid_bubble) begin
                IF_ID_Valid   <= 1'b0;
                IF_ID_Instr   <= NOP_INSTR;
                IF_ID_PCplus4 <= 32'h0;
            end else if (ifid_load) begin
                IF_ID_Valid   <= 1'b1;
                IF_ID_Instr   <= ifid_word;
                IF_ID_PCplus4 <= pc_plus4;
            end
        end
    end

    assign IF_ID_Opcode = IF_ID_Instr[31:26];
    assign IF_ID_Rs     = IF_ID_Instr[25:21];
    assign IF_ID_Rt     = IF_ID_Instr[20:16];
    assign IF_ID_Rd     = IF_ID_Instr[15:11];
    assign IF_ID_Shamt  = IF_ID_Instr[10:6];
    assign IF_ID_Func   = IF_ID_Instr[5:0];
    assign IF_ID_Imm    = IF_ID_Instr[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: scenario tasks drive a cycle table, push expected IF/ID contents
// into a scoreboard queue, and pop/compare them one edge later together with Imem_Req/Imem_Addr.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, PCSrc, Imem_Ready;
    logic [31:0] BranchTarget;
    logic        Imem_Req;
    logic [31:0] Imem_Addr, Imem_Data;
    logic        IF_ID_Valid;
    logic [31:0] IF_ID_Instr, IF_ID_PCplus4;
    logic [5:0]  IF_ID_Opcode, IF_ID_Func;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Shamt;
    logic [15:0] IF_ID_Imm;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ready(Imem_Ready), .Imem_Data(Imem_Data),
        .IF_ID_Valid(IF_ID_Valid), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCplus4(IF_ID_PCplus4),
        .IF_ID_Opcode(IF_ID_Opcode), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
        .IF_ID_Shamt(IF_ID_Shamt), .IF_ID_Func(IF_ID_Func), .IF_ID_Imm(IF_ID_Imm)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0F1E_2D3C;
    endfunction
    assign Imem_Data = mw(Imem_Addr);

    localparam int K_BUB = 0, K_VAL = 1, K_HLD = 2;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic        r, s, p;
        logic [31:0] bt;
        int          kind;
        logic [31:0] src;
        logic        req;
        logic [31:0] addr;
    } cyc_t;

    exp_t sbq[$];
    exp_t last_exp;
    cyc_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One table row: inputs for the cycle, expected IF/ID after the edge, expected Req/Addr after the edge.
    task automatic add(input logic r, input logic s, input logic p, input logic [31:0] bt,
                       input int kind, input logic [31:0] src, input logic req, input logic [31:0] addr);
        cyc_t c;
        c.r = r; c.s = s; c.p = p; c.bt = bt; c.kind = kind; c.src = src; c.req = req; c.addr = addr;
        tbl.push_back(c);
    endtask

    task automatic drive_push(input cyc_t c);
        exp_t e;
        Imem_Ready = c.r; Stall = c.s; PCSrc = c.p; BranchTarget = c.bt;
        case (c.kind)
            K_VAL:   begin e.v = 1'b1; e.instr = mw(c.src); e.pc4 = c.src + 32'd4; end
            K_HLD:   e = last_exp;
            default: begin e.v = 1'b0; e.instr = 32'h0; e.pc4 = 32'h0; end
        endcase
        last_exp = e;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Stall = 0; PCSrc = 0; BranchTarget = 0; Imem_Ready = 0;
        step(); step();
        checks++;
        if ({Imem_Req, Imem_Addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== 98'h0) begin
            errors++;
            $display("FAIL reset_state got req=%b addr=%h v=%b instr=%h pc4=%h want all zero",
                     Imem_Req, Imem_Addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4);
        end
        checks++;
        if ({IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Shamt, IF_ID_Func, IF_ID_Imm} !== 48'h0) begin
            errors++;
            $display("FAIL reset_fields got op=%h rs=%h imm=%h want 0", IF_ID_Opcode, IF_ID_Rs, IF_ID_Imm);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (Imem_Req !== 1'b0) begin
            errors++; $display("FAIL boot_req got %b want 0", Imem_Req);
        end
        step();
        checks++;
        if ({Imem_Req, Imem_Addr, IF_ID_Valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h v=%b want req=1 addr=0 v=0", Imem_Req, Imem_Addr, IF_ID_Valid);
        end
        last_exp = '{1'b0, 32'h0, 32'h0};
    endtask

    task automatic test_zero_wait();
        exp_t e;
        tbl.delete();
        add(1, 0, 0, 0, K_VAL, 32'h0, 1, 32'h4);
        add(1, 0, 0, 0, K_VAL, 32'h4, 1, 32'h8);
        add(1, 0, 0, 0, K_VAL, 32'h8, 1, 32'hC);
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL zero_wait_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Shamt, IF_ID_Func} !== e.instr ||
                IF_ID_Imm !== e.instr[15:0]) begin
                errors++;
                $display("FAIL zero_wait_fields[%0d] got op=%h rs=%h rt=%h rd=%h sh=%h fn=%h imm=%h want instr %h", i,
                         IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Shamt, IF_ID_Func, IF_ID_Imm, e.instr);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL zero_wait_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
    endtask

    task automatic test_slow_mem();
        exp_t e;
        tbl.delete();
        for (int k = 0; k < 2; k++) begin
            add(0, 0, 0, 0, K_BUB, 0, 1, 32'hC + 4 * k);
            add(0, 0, 0, 0, K_BUB, 0, 1, 32'hC + 4 * k);
            add(1, 0, 0, 0, K_VAL, 32'hC + 4 * k, 1, 32'h10 + 4 * k);
        end
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL slow_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL slow_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
    endtask

    task automatic test_stall_hold();
        exp_t e;
        tbl.delete();
        add(1, 1, 0, 0, K_HLD, 0, 0, 32'h14);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, K_HLD, 0, 0, 32'h14);
        add(0, 0, 0, 0, K_VAL, 32'h14, 1, 32'h18);
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL stall_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL stall_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
    endtask

    task automatic test_redirect_drain();
        exp_t e;
        tbl.delete();
        add(1, 0, 1, 32'h10, K_BUB, 0, 1, 32'h10);     // redirect with ready: next fetch at target
        add(0, 0, 1, 32'h40, K_BUB, 0, 1, 32'h10);     // redirect while 0x10 pending
        add(0, 0, 0, 0,      K_BUB, 0, 1, 32'h10);
        add(0, 1, 0, 0,      K_HLD, 0, 1, 32'h10);
        add(1, 0, 0, 0,      K_BUB, 0, 1, 32'h40);     // pending word discarded
        add(1, 0, 0, 0,      K_VAL, 32'h40, 1, 32'h44);
        add(0, 0, 1, 32'h80, K_BUB, 0, 1, 32'h44);
        add(0, 0, 1, 32'hC0, K_BUB, 0, 1, 32'h44);     // newer redirect replaces 0x80
        add(1, 0, 0, 0,      K_BUB, 0, 1, 32'hC0);
        add(1, 0, 0, 0,      K_VAL, 32'hC0, 1, 32'hC4);
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL drain_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL drain_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
    endtask

    task automatic test_hold_redirect();
        exp_t e;
        tbl.delete();
        add(1, 1, 0, 0,            K_HLD, 0, 0, 32'hC4);
        add(0, 1, 1, 32'h300,      K_BUB, 0, 1, 32'h300);  // PCSrc beats Stall, buffer dropped
        add(1, 0, 0, 0,            K_VAL, 32'h300, 1, 32'h304);
        add(1, 0, 1, 32'hFFFF_FFFC, K_BUB, 0, 1, 32'hFFFF_FFFC);
        add(1, 0, 0, 0,            K_VAL, 32'hFFFF_FFFC, 1, 32'h0);  // PC+4 wraps to 0
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL hold_redir_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL hold_redir_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        tbl.delete();
        add(1, 0, 1, 32'h1C, K_BUB, 0, 1, 32'h1C);
        add(1, 0, 0, 0,      K_VAL, 32'h1C, 1, 32'h20);
        add(0, 1, 0, 0,      K_HLD, 0, 1, 32'h20);     // waiting on 0x20, IF/ID held valid
        foreach (tbl[i]) begin
            drive_push(tbl[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4} !== {e.v, e.instr, e.pc4}) begin
                errors++;
                $display("FAIL rstmid_ifid[%0d] got %b/%h/%h want %b/%h/%h", i,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, e.v, e.instr, e.pc4);
            end
            checks++;
            if ({Imem_Req, Imem_Addr} !== {tbl[i].req, tbl[i].addr}) begin
                errors++;
                $display("FAIL rstmid_addr[%0d] got %b/%h want %b/%h", i, Imem_Req, Imem_Addr, tbl[i].req, tbl[i].addr);
            end
        end
        // Asynchronous reset mid-cycle, no clock edge in between.
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Imem_Req, Imem_Addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, IF_ID_Imm} !== 114'h0) begin
            errors++;
            $display("FAIL async_reset got req=%b addr=%h v=%b instr=%h pc4=%h imm=%h want all zero",
                     Imem_Req, Imem_Addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PCplus4, IF_ID_Imm);
        end
        Stall = 0; Imem_Ready = 0; PCSrc = 0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({Imem_Req, Imem_Addr, IF_ID_Valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL refetch got req=%b addr=%h v=%b want req=1 addr=0 v=0", Imem_Req, Imem_Addr, IF_ID_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall_hold();
        test_redirect_drain();
        test_hold_redirect();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
